// File: rtl/ldtu_sched_pkg.sv
// ldtu_sched_pkg: state encoding and default parameters shared by the serializer load scheduler.
package ldtu_sched_pkg;

    typedef enum logic [1:0] {IDLE, NORMAL, TEST, SWITCH} sched_state_t;

    localparam int          DEF_LOAD_PERIOD = 8;
    localparam logic [31:0] DEF_IDLE_WORD   = 32'hEAAA_AAAA;

endpackage

// File: rtl/ldtu_load_timer.sv
// ldtu_load_timer: free-running frame counter that flags the last cycle of every frame.
module ldtu_load_timer
    import ldtu_sched_pkg::*;
#(
    parameter int LOAD_PERIOD = DEF_LOAD_PERIOD,
    parameter int CNT_BITS    = $clog2(LOAD_PERIOD)
) (
    input  logic CLK,
    input  logic RST,
    output logic wrap
);

    localparam logic [CNT_BITS-1:0] LAST = CNT_BITS'(LOAD_PERIOD - 1);

    logic [CNT_BITS-1:0] cnt;

    assign wrap = cnt == LAST;

    always_ff @(posedge CLK or posedge RST)
        if (RST) cnt <= '0;
        else     cnt <= wrap ? '0 : cnt + 1'b1;

endmodule

// File: rtl/ldtu_ser_load_scheduler.sv
// ldtu_ser_load_scheduler: paces serializer loads and picks one coherent word source per frame.
module ldtu_ser_load_scheduler
    import ldtu_sched_pkg::*;
#(
    parameter int                  NBITS_32    = 32,
    parameter int                  LOAD_PERIOD = DEF_LOAD_PERIOD,
    parameter int                  CNT_BITS    = $clog2(LOAD_PERIOD),
    parameter logic [NBITS_32-1:0] IDLE_WORD   = DEF_IDLE_WORD,
    parameter int                  UND_BITS    = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                TEST_ENABLE,
    input  logic                dtu_valid,
    output logic                dtu_ready,
    input  logic [NBITS_32-1:0] DATA32_0,
    input  logic [NBITS_32-1:0] DATA32_1,
    input  logic [NBITS_32-1:0] DATA32_2,
    input  logic [NBITS_32-1:0] DATA32_3,
    input  logic [NBITS_32-1:0] DATA32_ATU_0,
    input  logic [NBITS_32-1:0] DATA32_ATU_1,
    input  logic [NBITS_32-1:0] DATA32_ATU_2,
    input  logic [NBITS_32-1:0] DATA32_ATU_3,
    output logic [NBITS_32-1:0] ser_data_0,
    output logic [NBITS_32-1:0] ser_data_1,
    output logic [NBITS_32-1:0] ser_data_2,
    output logic [NBITS_32-1:0] ser_data_3,
    output logic                handshake,
    output logic                mode_test,
    output logic                underrun,
    output logic [UND_BITS-1:0] underrun_cnt
);

    logic                     wrap, sw, load_normal, load_test, mode_d, under_d;
    sched_state_t             state, state_d;
    logic [3:0][NBITS_32-1:0] enc, atu, lanes, lanes_d;

    ldtu_load_timer #(.LOAD_PERIOD(LOAD_PERIOD), .CNT_BITS(CNT_BITS)) u_timer (
        .CLK  (CLK),
        .RST  (RST),
        .wrap (wrap)
    );

    assign enc = {DATA32_3, DATA32_2, DATA32_1, DATA32_0};
    assign atu = {DATA32_ATU_3, DATA32_ATU_2, DATA32_ATU_1, DATA32_ATU_0};
    assign {ser_data_3, ser_data_2, ser_data_1, ser_data_0} = lanes;
    assign dtu_ready = load_normal;

    // SWITCH frames resolve to the rules of the mode they are heading into
    always_comb begin
        state_d     = state;
        mode_d      = mode_test;
        lanes_d     = lanes;
        sw          = (state == NORMAL || state == TEST) && (TEST_ENABLE != mode_test);
        load_normal = wrap && !sw && (state == NORMAL || (state == SWITCH && !mode_test));
        load_test   = wrap && !sw && (state == TEST   || (state == SWITCH &&  mode_test));
        under_d     = load_normal && !dtu_valid;
        if (wrap) begin
            if (state == IDLE) begin
                state_d = TEST_ENABLE ? TEST : NORMAL;
                mode_d  = TEST_ENABLE;
                lanes_d = {4{IDLE_WORD}};
            end else if (sw) begin
                state_d = SWITCH;
                mode_d  = !mode_test;
                lanes_d = {4{IDLE_WORD}};
            end else begin
                state_d = mode_test ? TEST : NORMAL;
                lanes_d = load_test ? atu : (dtu_valid ? enc : {4{IDLE_WORD}});
            end
        end
    end

    always_ff @(posedge CLK or posedge RST)
        if (RST) begin
            state        <= IDLE;
            mode_test    <= 1'b0;
            lanes        <= {4{IDLE_WORD}};
            handshake    <= 1'b0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            state     <= state_d;
            mode_test <= mode_d;
            lanes     <= lanes_d;
            handshake <= wrap;
            underrun  <= under_d;
            if (under_d && !(&underrun_cnt)) underrun_cnt <= underrun_cnt + 1'b1;
        end

endmodule

// File: tb/tb_ldtu_ser_load_scheduler.sv
// tb_ldtu_ser_load_scheduler: directed frames with a scoreboard of expected serializer loads.
module tb_ldtu_ser_load_scheduler;

    localparam logic [31:0] IW = 32'hEAAA_AAAA;

    typedef struct packed {
        logic [3:0][31:0] l;
        logic             und;
        logic             mode;
        logic             rdy;
        logic [7:0]       ucnt;
    } exp_t;

    logic             CLK = 1'b0, RST = 1'b1, TEST_ENABLE = 1'b0, dtu_valid = 1'b0;
    logic             dtu_ready, handshake, mode_test, underrun;
    logic [3:0][31:0] enc = '0, atu = '0, ser;
    logic [7:0]       underrun_cnt;

    int   checks = 0, errors = 0, gap = 0;
    logic hold_mode = 1'b0, rdy_seen = 1'b0;
    exp_t sb[$];

    ldtu_ser_load_scheduler dut (
        .CLK(CLK), .RST(RST), .TEST_ENABLE(TEST_ENABLE),
        .dtu_valid(dtu_valid), .dtu_ready(dtu_ready),
        .DATA32_0(enc[0]), .DATA32_1(enc[1]), .DATA32_2(enc[2]), .DATA32_3(enc[3]),
        .DATA32_ATU_0(atu[0]), .DATA32_ATU_1(atu[1]), .DATA32_ATU_2(atu[2]), .DATA32_ATU_3(atu[3]),
        .ser_data_0(ser[0]), .ser_data_1(ser[1]), .ser_data_2(ser[2]), .ser_data_3(ser[3]),
        .handshake(handshake), .mode_test(mode_test),
        .underrun(underrun), .underrun_cnt(underrun_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0][31:0] lanes_of(input logic [31:0] base);
        return {base + 32'd3, base + 32'd2, base + 32'd1, base};
    endfunction

    // one frame: queue its expected load, then wiggle TEST_ENABLE mid-frame
    task automatic frame(input logic [3:0][31:0] l, input logic und, mode, rdy,
                         input logic [7:0] uc, input logic te_mid, te_end);
        exp_t e;
        e.l = l; e.und = und; e.mode = mode; e.rdy = rdy; e.ucnt = uc;
        sb.push_back(e);
        repeat (2) @(negedge CLK);
        TEST_ENABLE = te_mid;
        repeat (2) @(negedge CLK);
        TEST_ENABLE = te_end;
        repeat (4) @(negedge CLK);
    endtask

    // edges since reset release or since the last handshake
    always @(posedge CLK) gap <= RST ? 0 : (handshake ? 1 : gap + 1);

    always @(negedge CLK) begin
        if (RST) begin
            hold_mode = 1'b0;
            rdy_seen  = 1'b0;
        end else begin
            if (dtu_ready) rdy_seen = 1'b1;
            if (handshake) begin
                if (sb.size() == 0) chk("unexpected_handshake", 128'd1, 128'd0);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("lanes", ser, e.l);
                    chk("underrun", 128'(underrun), 128'(e.und));
                    chk("mode_test", 128'(mode_test), 128'(e.mode));
                    chk("dtu_ready_in_frame", 128'(rdy_seen), 128'(e.rdy));
                    chk("underrun_cnt", 128'(underrun_cnt), 128'(e.ucnt));
                    chk("handshake_period", 128'(gap), 128'd8);
                end
                hold_mode = mode_test;
                rdy_seen  = 1'b0;
            end else begin
                chk("underrun_idle", 128'(underrun), 128'd0);
                chk("mode_glitch", 128'(mode_test), 128'(hold_mode));
            end
        end
    end

    initial begin
        logic [3:0][31:0] idle4, d1, d2, d3, d4;
        idle4 = {4{IW}};
        d1 = lanes_of(32'h1000_0000);
        d2 = lanes_of(32'h2000_0000);
        d3 = lanes_of(32'h3000_0000);
        d4 = lanes_of(32'h4000_0000);
        enc = d1;
        dtu_valid = 1'b1;
        repeat (3) @(negedge CLK);
        #1;
        chk("rst_lanes", ser, idle4);
        chk("rst_handshake", 128'(handshake), 128'd0);
        chk("rst_ucnt", 128'(underrun_cnt), 128'd0);
        chk("rst_ready", 128'(dtu_ready), 128'd0);
        @(negedge CLK);
        RST = 1'b0;
        frame(idle4, 0, 0, 0, 8'd0, 0, 0);
        frame(d1,    0, 0, 1, 8'd0, 0, 0);
        frame(d1,    0, 0, 1, 8'd0, 0, 0);
        dtu_valid = 1'b0;
        for (int i = 1; i <= 3; i++) frame(idle4, 1, 0, 1, 8'(i), 0, 0);
        dtu_valid = 1'b1;
        enc = d2;
        frame(d2,    0, 0, 1, 8'd3, 0, 0);
        frame(idle4, 0, 1, 0, 8'd3, 1, 1);
        atu = lanes_of(32'hA000_0000);
        frame(lanes_of(32'hA000_0000), 0, 1, 0, 8'd3, 1, 1);
        atu = lanes_of(32'hB000_0000);
        frame(lanes_of(32'hB000_0000), 0, 1, 0, 8'd3, 0, 1);
        frame(idle4, 0, 0, 0, 8'd3, 0, 0);
        enc = d3;
        frame(d3,    0, 0, 1, 8'd3, 1, 0);
        dtu_valid = 1'b0;
        for (int i = 1; i <= 300; i++)
            frame(idle4, 1, 0, 1, (3 + i > 255) ? 8'd255 : 8'(3 + i), 0, 0);
        dtu_valid = 1'b1;
        enc = d4;
        frame(d4,    0, 0, 1, 8'd255, 0, 0);
        repeat (4) @(negedge CLK);
        RST = 1'b1;
        #1;
        chk("midrst_lanes", ser, idle4);
        chk("midrst_handshake", 128'(handshake), 128'd0);
        chk("midrst_mode", 128'(mode_test), 128'd0);
        chk("midrst_underrun", 128'(underrun), 128'd0);
        chk("midrst_ucnt", 128'(underrun_cnt), 128'd0);
        chk("midrst_ready", 128'(dtu_ready), 128'd0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        frame(idle4, 0, 0, 0, 8'd0, 0, 0);
        frame(d4,    0, 0, 1, 8'd0, 0, 0);
        repeat (2) @(negedge CLK);
        chk("scoreboard_drained", 128'(sb.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ldtu_ser_load_scheduler.md
# ldtu_ser_load_scheduler

Frame scheduler between the LiTE-DTU datapath and the four-lane serializer. It paces word loading with a periodic `handshake` strobe and selects, per frame, between encoder words, ADC-test-unit (ATU) words and idle filler. It also sequences clean mode switches when `TEST_ENABLE` changes and counts encoder underruns. It replaces direct wiring of `DATA32_*`/`handshake` into the serializer, so the serializer sees exactly one coherent source per frame.

## Interface
- `NBITS_32`, 32, lane word width
- `LOAD_PERIOD`, 8, CLK cycles per frame (≥2)
- `CNT_BITS`, 3, width of frame counter, = clog2(`LOAD_PERIOD`)
- `IDLE_WORD`, 32'hEAAA_AAAA, filler word loaded on all lanes when no data
- `UND_BITS`, 8, underrun counter width

Ports:
- `CLK`  in  1  single clock for the whole block
- `RST`  in  1  asynchronous, active-high reset
- `TEST_ENABLE`  in  1  requested mode: 1 = ATU words, 0 = encoder words
- `dtu_valid`  in  1  encoder has a 4-lane word set available
- `dtu_ready`  out  1  scheduler accepts the encoder word set this cycle
- `DATA32_0`..`DATA32_3`  in  32 each  encoder lane words
- `DATA32_ATU_0`..`DATA32_ATU_3`  in  32 each  ATU lane words, free-running, no handshake
- `ser_data_0`..`ser_data_3`  out  32 each  registered words to serializer lanes
- `handshake`  out  1  one-cycle load strobe to serializer
- `mode_test`  out  1  effective mode currently driven (1 = ATU)
- `underrun`  out  1  one-cycle pulse: NORMAL frame filled with idle words
- `underrun_cnt`  out  `UND_BITS`  saturating underrun count

## Operation
- Frame counter `cnt` runs 0…`LOAD_PERIOD`-1 and wraps. The cycle with `cnt == LOAD_PERIOD-1` is the *wrap cycle*. All source selection, mode sampling and state transitions happen only at the wrap edge.
- States:
  - IDLE: after reset. At the first wrap, loads `IDLE_WORD` and goes to NORMAL if `TEST_ENABLE`=0, else TEST.
  - NORMAL: `dtu_ready` = 1 in the wrap cycle only (combinational from state and `cnt`).
    - If `dtu_valid`=1, loads `DATA32_0..3`.
    - If `dtu_valid`=0, loads `IDLE_WORD` on all lanes, pulses `underrun` and increments `underrun_cnt`.
  - TEST: `dtu_ready`=0. Loads `DATA32_ATU_0..3` as sampled at the wrap edge. No underrun accounting.
  - SWITCH: entered from NORMAL or TEST when the `TEST_ENABLE` sampled at the wrap differs from `mode_test`.
    - The frame loaded at that wrap is `IDLE_WORD`. `dtu_ready`=0 in that cycle.
    - `mode_test` toggles at the same edge.
    - At the next wrap, goes to the state matching the new `mode_test` (TEST or NORMAL), and loads per that state's rules.
    - A `TEST_ENABLE` change while in SWITCH is ignored until that next wrap.
- Lane mapping is identity: input lane k → `ser_data_k`. Lanes always load together.
- `underrun_cnt` saturates at 2^`UND_BITS`-1. At saturation, `underrun` still pulses.
- A word set is consumed only when `dtu_valid & dtu_ready`. The encoder must hold its data while `dtu_ready`=0.

## Timing
- Reset values: `cnt`=0, state IDLE, `ser_data_*`=`IDLE_WORD`, `handshake`=0, `mode_test`=0, `underrun`=0, `underrun_cnt`=0, `dtu_ready`=0.
- `ser_data_*`, `handshake`, `mode_test`, `underrun` and `underrun_cnt` are registered and update at the wrap edge.
- `handshake` is high for exactly one cycle, the cycle after each wrap edge, and new data is already stable on `ser_data_*` in that cycle. Data then holds for `LOAD_PERIOD` cycles.
- First `handshake` after reset release: `LOAD_PERIOD` edges later.
- Latency from accepted encoder word (`dtu_ready & dtu_valid` cycle) to `ser_data_*`: 1 cycle.
- Reset mid-frame: all outputs return to reset values immediately (async). The frame in flight is discarded and the encoder word set is not consumed.

## Structure
- Shared package `ldtu_sched_pkg`:
  - state enum IDLE/NORMAL/TEST/SWITCH
  - `IDLE_WORD` default
  - `LOAD_PERIOD` default
- One sub-module `ldtu_load_timer`: frame counter with `wrap` output, parameterised by `LOAD_PERIOD`/`CNT_BITS`.
- The FSM and lane registers live in the top of the block.

## Test plan
- Reset release, `TEST_ENABLE`=0, `dtu_valid`=1 with `DATA32_k`=32'h1000_000k:
  - first `handshake` at edge 8 with `IDLE_WORD`;
  - second `handshake` at edge 16 with 32'h1000_000k on lane k;
  - `handshake` period 8.
- NORMAL with `dtu_valid`=0 for 3 frames: 3 `underrun` pulses, `underrun_cnt`=3, lanes = 32'hEAAA_AAAA, `dtu_ready` pulses ignored.
- `TEST_ENABLE` 0→1 mid-frame:
  - next wrap loads idle and `mode_test`=1 (SWITCH);
  - the following wrap loads `DATA32_ATU_k`;
  - no `dtu_ready` during TEST.
- `TEST_ENABLE` toggled 1→0→1 within one SWITCH frame: single SWITCH frame, then TEST resumes; no glitch on `mode_test`.
- Force 300 consecutive underruns: `underrun_cnt` holds at 255, `underrun` keeps pulsing.
- Assert `RST` at `cnt`=4 while `dtu_valid`=1: outputs reset at once, the word is not consumed, and the first post-reset `handshake` comes 8 edges after release.
